// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use, FP RAW and structural stalls against one
// in-flight multi-cycle FP op (FDIV/FSQRT), branch flush, and a stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int unsigned MC_TIMEOUT = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_use_stall_i,
    input  logic        branch_taken_i,
    input  logic        mc_start_i,
    input  logic [4:0]  mc_rd_i,
    input  logic        mc_done_i,
    input  logic [4:0]  id_fp_rs1_i,
    input  logic [4:0]  id_fp_rs2_i,
    input  logic [4:0]  id_fp_rs3_i,
    input  logic [4:0]  id_fp_rd_i,
    input  logic [3:0]  id_fp_use_i,
    input  logic        id_is_mc_i,
    output logic        pc_write_o,
    output logic        if_id_write_o,
    output logic        if_id_flush_o,
    output logic        id_ex_bubble_o,
    output logic        mc_busy_o,
    output logic        mc_timeout_o,
    output logic        mc_proto_err_o,
    output logic [15:0] stall_cycles_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } state_e;

    localparam logic [5:0] CNT_LAST = 6'(MC_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [4:0]  pend_rd_q, pend_rd_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic        busy_s, raw_hit_s, struct_hit_s, stall_s;

    assign busy_s       = (state_q == ST_BUSY);
    // f0 is a real FP register, so no zero-register exclusion here.
    assign raw_hit_s    = busy_s & ((id_fp_use_i[0] & (id_fp_rs1_i == pend_rd_q)) |
                                    (id_fp_use_i[1] & (id_fp_rs2_i == pend_rd_q)) |
                                    (id_fp_use_i[2] & (id_fp_rs3_i == pend_rd_q)) |
                                    (id_fp_use_i[3] & (id_fp_rd_i  == pend_rd_q)));
    assign struct_hit_s = busy_s & id_is_mc_i;
    assign stall_s      = (load_use_stall_i | raw_hit_s | struct_hit_s) & ~branch_taken_i;

    // Next-state logic of the multi-cycle op tracker and the stall counter.
    always_comb begin
        state_d        = state_q;
        pend_rd_d      = pend_rd_q;
        cnt_d          = cnt_q;
        stall_cycles_d = stall_cycles_q;
        case (state_q)
            ST_IDLE, ST_ABORT: begin
                if (mc_start_i) begin
                    state_d   = ST_BUSY;
                    pend_rd_d = mc_rd_i;
                    cnt_d     = 6'd0;
                end else if (state_q == ST_ABORT) begin
                    state_d   = ST_IDLE;
                    pend_rd_d = 5'd0;
                    cnt_d     = 6'd0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // A write-back in the deadline cycle still completes normally.
                if (mc_done_i) begin
                    if (mc_start_i) begin
                        state_d   = ST_BUSY;
                        pend_rd_d = mc_rd_i;
                        cnt_d     = 6'd0;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_ABORT;
                    pend_rd_d = 5'd0;
                    cnt_d     = 6'd0;
                end else begin
                    cnt_d     = cnt_q + 6'd1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                pend_rd_d = 5'd0;
                cnt_d     = 6'd0;
            end
        endcase
        if (stall_s && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            pend_rd_q      <= 5'd0;
            cnt_q          <= 6'd0;
            stall_cycles_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            pend_rd_q      <= pend_rd_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Pipeline control; a taken branch overrides any stall and does not touch the FSM.
    always_comb begin
        if (!rst_ni) begin
            {pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o} = 4'b0001;
        end else if (branch_taken_i) begin
            {pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o} = 4'b1111;
        end else if (stall_s) begin
            {pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o} = 4'b0001;
        end else begin
            {pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o} = 4'b1100;
        end
    end

    assign mc_busy_o      = busy_s;
    assign mc_timeout_o   = (state_q == ST_ABORT);
    assign mc_proto_err_o = busy_s & mc_start_i & ~mc_done_i;
    assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a cycle-ordered vector table checked via a
// scoreboard queue, then hand-written timeout, saturation and async-reset sequences.
module tb_pipe_hazard_ctrl;

    localparam int unsigned TMO = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        load_use_stall_i, branch_taken_i, mc_start_i, mc_done_i, id_is_mc_i;
    logic [4:0]  mc_rd_i, id_fp_rs1_i, id_fp_rs2_i, id_fp_rs3_i, id_fp_rd_i;
    logic [3:0]  id_fp_use_i;
    logic        pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o;
    logic        mc_busy_o, mc_timeout_o, mc_proto_err_o;
    logic [15:0] stall_cycles_o;

    always #5 clk_i = ~clk_i;

    pipe_hazard_ctrl #(.MC_TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .load_use_stall_i(load_use_stall_i), .branch_taken_i(branch_taken_i),
        .mc_start_i(mc_start_i), .mc_rd_i(mc_rd_i), .mc_done_i(mc_done_i),
        .id_fp_rs1_i(id_fp_rs1_i), .id_fp_rs2_i(id_fp_rs2_i),
        .id_fp_rs3_i(id_fp_rs3_i), .id_fp_rd_i(id_fp_rd_i),
        .id_fp_use_i(id_fp_use_i), .id_is_mc_i(id_is_mc_i),
        .pc_write_o(pc_write_o), .if_id_write_o(if_id_write_o),
        .if_id_flush_o(if_id_flush_o), .id_ex_bubble_o(id_ex_bubble_o),
        .mc_busy_o(mc_busy_o), .mc_timeout_o(mc_timeout_o),
        .mc_proto_err_o(mc_proto_err_o), .stall_cycles_o(stall_cycles_o)
    );

    // {pc_write, if_id_write, if_id_flush, id_ex_bubble}
    localparam logic [3:0] P_RUN = 4'b1100;
    localparam logic [3:0] P_STL = 4'b0001;
    localparam logic [3:0] P_BR  = 4'b1111;
    // {mc_busy, mc_timeout, mc_proto_err}
    localparam logic [2:0] S_I  = 3'b000;
    localparam logic [2:0] S_B  = 3'b100;
    localparam logic [2:0] S_A  = 3'b010;
    localparam logic [2:0] S_PE = 3'b101;

    typedef struct {
        logic        lus, br, ms, md, ismc;
        logic [4:0]  mrd, rs1, rs2, rs3, rd;
        logic [3:0]  use_v;
        logic [6:0]  exp_ctl;
        logic [15:0] exp_sc;
    } vec_t;

    typedef struct {
        logic [6:0]  ctl;
        logic [15:0] sc;
        int          idx;
    } exp_t;

    vec_t vecs[21];
    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(logic lus, logic br, logic ms, logic [4:0] mrd, logic md,
                                logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rs3,
                                logic [4:0] rd, logic [3:0] use_v, logic ismc,
                                logic [6:0] ctl, logic [15:0] sc);
        vec_t v;
        v.lus = lus; v.br = br; v.ms = ms; v.mrd = mrd; v.md = md;
        v.rs1 = rs1; v.rs2 = rs2; v.rs3 = rs3; v.rd = rd; v.use_v = use_v;
        v.ismc = ismc; v.exp_ctl = ctl; v.exp_sc = sc;
        return v;
    endfunction

    function automatic logic [6:0] ctl_now();
        return {pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
                mc_busy_o, mc_timeout_o, mc_proto_err_o};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic clear_inputs();
        load_use_stall_i = 1'b0; branch_taken_i = 1'b0; mc_start_i = 1'b0;
        mc_done_i = 1'b0; id_is_mc_i = 1'b0; mc_rd_i = 5'd0;
        id_fp_rs1_i = 5'd0; id_fp_rs2_i = 5'd0; id_fp_rs3_i = 5'd0; id_fp_rd_i = 5'd0;
        id_fp_use_i = 4'd0;
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        clear_inputs();
        #2 rst_ni = 1'b1;
    endtask

    task automatic drive_vec(input int idx);
        exp_t e;
        @(posedge clk_i); #1;
        load_use_stall_i = vecs[idx].lus; branch_taken_i = vecs[idx].br;
        mc_start_i = vecs[idx].ms; mc_rd_i = vecs[idx].mrd; mc_done_i = vecs[idx].md;
        id_fp_rs1_i = vecs[idx].rs1; id_fp_rs2_i = vecs[idx].rs2;
        id_fp_rs3_i = vecs[idx].rs3; id_fp_rd_i = vecs[idx].rd;
        id_fp_use_i = vecs[idx].use_v; id_is_mc_i = vecs[idx].ismc;
        e.ctl = vecs[idx].exp_ctl; e.sc = vecs[idx].exp_sc; e.idx = idx;
        sb_q.push_back(e);
    endtask

    task automatic check_vec();
        exp_t e;
        @(negedge clk_i);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk($sformatf("vec%0d_ctl", e.idx), {25'd0, ctl_now()}, {25'd0, e.ctl});
            chk($sformatf("vec%0d_stall_cycles", e.idx), {16'd0, stall_cycles_o}, {16'd0, e.sc});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen;
        rst_ni = 1'b0;
        clear_inputs();
        #3;
        chk("reset_ctl", {25'd0, ctl_now()}, {25'd0, 7'b0001_000});
        chk("reset_stall_cycles", {16'd0, stall_cycles_o}, 32'd0);
        #9 rst_ni = 1'b1;

        //          lus br ms mrd   md rs1   rs2   rs3   rd    use    ismc  ctl           sc
        vecs[0]  = mk(0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 4'h0, 0, {P_RUN, S_I},  16'd0);
        vecs[1]  = mk(1, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 4'h0, 0, {P_STL, S_I},  16'd0);
        vecs[2]  = mk(0, 0, 1, 5'd5, 0, 5'd0, 5'd0, 5'd0, 5'd0, 4'h0, 0, {P_RUN, S_I},  16'd1);
        vecs[3]  = mk(0, 0, 0, 5'd0, 0, 5'd0, 5'd5, 5'd0, 5'd0, 4'h2, 0, {P_STL, S_B},  16'd1);
        vecs[4]  = mk(0, 0, 0, 5'd0, 1, 5'd0, 5'd5, 5'd0, 5'd0, 4'h2, 0, {P_STL, S_B},  16'd2);
        vecs[5]  = mk(0, 0, 0, 5'd0, 0, 5'd0, 5'd5, 5'd0, 5'd0, 4'h2, 0, {P_RUN, S_I},  16'd3);
        vecs[6]  = mk(0, 0, 1, 5'd5, 0, 5'd0, 5'd0, 5'd0, 5'd0, 4'h0, 0, {P_RUN, S_I},  16'd3);
        vecs[7]  = mk(0, 0, 0, 5'd0, 0, 5'd0, 5'd6, 5'd0, 5'd0, 4'h2, 0, {P_RUN, S_B},  16'd3);
        vecs[8]  = mk(0, 1, 0, 5'd0, 0, 5'd5, 5'd0, 5'd0, 5'd0, 4'h1, 0, {P_BR,  S_B},  16'd3);
        vecs[9]  = mk(0, 0, 1, 5'd9, 1, 5'd0, 5'd0, 5'd0, 5'd5, 4'h8, 0, {P_STL, S_B},  16'd3);
        vecs[10] = mk(0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd9, 5'd0, 4'h4, 0, {P_STL, S_B},  16'd4);
        vecs[11] = mk(0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd5, 5'd0, 4'h4, 0, {P_RUN, S_B},  16'd5);
        vecs[12] = mk(0, 0, 1, 5'd3, 0, 5'd0, 5'd0, 5'd0, 5'd0, 4'h0, 0, {P_RUN, S_PE}, 16'd5);
        vecs[13] = mk(0, 0, 0, 5'd0, 0, 5'd9, 5'd0, 5'd0, 5'd0, 4'h1, 0, {P_STL, S_B},  16'd5);
        vecs[14] = mk(0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 4'h0, 0, {P_RUN, S_A},  16'd6);
        vecs[15] = mk(0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 4'h0, 1, {P_RUN, S_I},  16'd6);
        vecs[16] = mk(0, 0, 1, 5'd0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 4'h0, 0, {P_RUN, S_I},  16'd6);
        vecs[17] = mk(0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 4'h0, 1, {P_STL, S_B},  16'd6);
        vecs[18] = mk(0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 4'h1, 0, {P_STL, S_B},  16'd7);
        vecs[19] = mk(0, 0, 0, 5'd0, 1, 5'd0, 5'd0, 5'd0, 5'd0, 4'h0, 0, {P_RUN, S_B},  16'd8);
        vecs[20] = mk(0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 4'h1, 1, {P_RUN, S_I},  16'd8);

        for (int i = 0; i < 21; i++) begin
            drive_vec(i);
            check_vec();
        end

        // Timeout: busy for exactly TMO cycles, then a one-cycle abort, then idle.
        do_reset();
        @(posedge clk_i); #1;
        mc_start_i = 1'b1; mc_rd_i = 5'd1;
        @(posedge clk_i); #1;
        mc_start_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_i);
            chk($sformatf("tmo_busy_c%0d", i), {31'd0, mc_busy_o}, {31'd0, (i < 4)});
            chk($sformatf("tmo_pulse_c%0d", i), {31'd0, mc_timeout_o}, {31'd0, (i == 4)});
        end

        // A start request arriving in the abort cycle is captured.
        @(posedge clk_i); #1;
        mc_start_i = 1'b1; mc_rd_i = 5'd1;
        @(posedge clk_i); #1;
        mc_start_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_i);
            if (mc_timeout_o) seen = 1'b1;
        end
        chk("abort_seen", {31'd0, seen}, 32'd1);
        mc_start_i = 1'b1; mc_rd_i = 5'd7; id_fp_rs1_i = 5'd7; id_fp_use_i = 4'h1;
        @(posedge clk_i); #1;
        mc_start_i = 1'b0;
        @(negedge clk_i);
        chk("abort_capture_busy", {31'd0, mc_busy_o}, 32'd1);
        chk("abort_capture_raw", {31'd0, pc_write_o}, 32'd0);

        // Saturating stall counter.
        do_reset();
        @(posedge clk_i); #1;
        load_use_stall_i = 1'b1;
        repeat (65540) @(posedge clk_i);
        @(negedge clk_i);
        chk("stall_sat", {16'd0, stall_cycles_o}, 32'h0000_FFFF);
        chk("stall_sat_pc", {31'd0, pc_write_o}, 32'd0);

        // Asynchronous reset in the middle of an in-flight op.
        @(posedge clk_i); #1;
        load_use_stall_i = 1'b0; mc_start_i = 1'b1; mc_rd_i = 5'd2;
        @(posedge clk_i); #1;
        mc_start_i = 1'b0; id_fp_rs1_i = 5'd2; id_fp_use_i = 4'h1;
        @(negedge clk_i);
        chk("mid_busy_raw_ctl", {25'd0, ctl_now()}, {25'd0, P_STL, S_B});
        #1 rst_ni = 1'b0;
        #1;
        chk("async_rst_ctl", {25'd0, ctl_now()}, {25'd0, 7'b0001_000});
        chk("async_rst_sc", {16'd0, stall_cycles_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_rst_ctl", {25'd0, ctl_now()}, {25'd0, P_RUN, S_I});
        chk("post_rst_sc", {16'd0, stall_cycles_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: MC_TIMEOUT, default 32, maximum cycles a multi-cycle FP op (FDIV/FSQRT) may stay in flight before abort; legal range 2..63.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 load_use_stall  in  1  integer load-use hazard request from the stalling unit.
REQ-005 branch_taken  in  1  EX-stage redirect (taken branch/JAL/JALR).
REQ-006 mc_start  in  1  multi-cycle FP op leaves EX this cycle.
REQ-007 mc_rd  in  5  destination f-register of the issuing multi-cycle op.
REQ-008 mc_done  in  1  FPU result write-back pulse for the in-flight op.
REQ-009 id_fp_rs1, id_fp_rs2, id_fp_rs3, id_fp_rd  in  5 each  f-register fields of the IF/ID instruction.
REQ-010 id_fp_use  in  4  valid bits {rd,rs3,rs2,rs1} for those fields.
REQ-011 id_is_mc  in  1  IF/ID instruction is itself a multi-cycle FP op.
REQ-012 pc_write  out  1  PC update enable.
REQ-013 if_id_write  out  1  IF/ID register load enable.
REQ-014 if_id_flush  out  1  clear IF/ID to NOP.
REQ-015 id_ex_bubble  out  1  insert NOP into ID/EX.
REQ-016 mc_busy  out  1  multi-cycle op in flight (state BUSY).
REQ-017 mc_timeout  out  1  one-cycle abort pulse.
REQ-018 mc_proto_err  out  1  one-cycle pulse: mc_start seen while BUSY without mc_done.
REQ-019 stall_cycles  out  16  saturating count of stalled cycles.

Function
REQ-020 FSM states IDLE, BUSY, ABORT; registered pend_rd[4:0], age counter cnt[5:0].
REQ-021 IDLE: mc_start -> BUSY, pend_rd<=mc_rd, cnt<=0.
REQ-022 BUSY: mc_done & ~mc_start -> IDLE; mc_done & mc_start -> stay BUSY, pend_rd<=mc_rd, cnt<=0; neither -> cnt+1.
REQ-023 BUSY with cnt==MC_TIMEOUT-1 and no mc_done -> ABORT; mc_done in that same cycle wins (-> IDLE).
REQ-024 ABORT lasts exactly one cycle, mc_timeout=1, pend_rd cleared, then IDLE; mc_start in ABORT is captured as in IDLE.
REQ-025 mc_start in BUSY without mc_done: mc_proto_err=1 that cycle, request ignored, state/pend_rd/cnt unchanged except normal increment.
REQ-026 raw_hit = mc_busy & any valid id_fp field (rs1/rs2/rs3/rd per id_fp_use) equal to pend_rd; f0 is a real register, no zero exclusion.
REQ-027 struct_hit = mc_busy & id_is_mc.
REQ-028 stall = (load_use_stall | raw_hit | struct_hit) & ~branch_taken; computed combinationally from inputs and registered state, zero latency.
REQ-029 mc_done cycle still counts as BUSY for raw_hit/struct_hit; dependent instruction released the following cycle.
REQ-030 stall: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0.
REQ-031 branch_taken (highest priority): pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1; does not affect FSM (in-flight op is older and completes).
REQ-032 Neither: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0.
REQ-033 stall_cycles increments by 1 each cycle stall=1; holds at 16'hFFFF.

Reset
REQ-034 rst_n low: state IDLE, pend_rd=0, cnt=0, stall_cycles=0, mc_timeout=0, mc_proto_err=0 immediately (asynchronous).
REQ-035 While rst_n low: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1, mc_busy=0; reset mid-BUSY discards the op.

Verification
REQ-036 load_use_stall=1 one cycle in IDLE -> pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle; stall_cycles=1 after.
REQ-037 mc_start, mc_rd=5, then id_fp_rs2=5 valid -> stall held until cycle after mc_done; release next cycle; id_fp_rs2=6 -> no stall.
REQ-038 BUSY with raw_hit and branch_taken same cycle -> if_id_flush=1, pc_write=1, stall=0; FSM stays BUSY.
REQ-039 MC_TIMEOUT=4, mc_start, no mc_done -> mc_busy 4 cycles, mc_timeout pulse 1 cycle, IDLE after.
REQ-040 BUSY, mc_done & mc_start same cycle with mc_rd=9 -> stays BUSY, pend_rd=9, cnt=0; mc_start alone while BUSY -> mc_proto_err pulse.
REQ-041 Force 65540 stall cycles -> stall_cycles=16'hFFFF; assert rst_n=0 mid-BUSY -> all registers cleared asynchronously.
